// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined core front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int D_DEFAULT  = 10;   // program-counter width
    localparam int IW_DEFAULT = 9;    // instruction width
    localparam int CW_DEFAULT = 16;   // performance-counter width

    // Halt is the all-ones encoding, NOP the all-zeros encoding. Users
    // replicate bit 0 to whatever instruction width they are built with.
    localparam logic [IW_DEFAULT-1:0] HALT_CODE = '1;
    localparam logic [IW_DEFAULT-1:0] NOP_CODE  = '0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: hold, absolute load, or increment with wrap.
// Latency: new PC visible one cycle after the controlling inputs.
// Backpressure: hold has priority over load; load over increment.
//
// Ports:
//   clk      core clock
//   rst_n    asynchronous active-low reset, loads START
//   hold     keep current PC
//   load     take load_val (branch target)
//   load_val absolute target
//   pc       current program counter
module fetch_pc
    import cpu_pkg::*;
#(
    parameter int           D     = D_DEFAULT,
    parameter logic [D-1:0] START = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         load,
    input  logic [D-1:0] load_val,
    output logic [D-1:0] pc
);

    localparam logic [D-1:0] PC_ONE = {{(D-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= START;
        end else if (hold) begin
            pc <= pc;
        end else if (load) begin
            pc <= load_val;
        end else begin
            // Natural D-bit overflow gives the wrap to 0.
            pc <= pc + PC_ONE;
        end
    end

endmodule

// File: rtl/fetch_pipe.sv
// Instruction-fetch front end: PC, IF/ID register, halt FSM, cycle/retire counters.
// Latency: instruction at imem_addr A appears on id_instr one cycle later; branch costs one bubble.
// Backpressure: stall holds PC and IF/ID; stall outranks branch_en; HALT freezes everything until reset.
//
// Ports:
//   clk, reset                  core clock, async active-low reset
//   stall                       hold PC and IF/ID
//   branch_en, branch_target    taken branch from ID, absolute target
//   imem_addr, imem_data        instruction ROM address (= pc) and combinational data
//   id_valid, id_instr, id_pc   IF/ID stage contents
//   done                        sticky halt indicator
//   cycle_count, retire_count   saturating RUN-cycle and retired-instruction counters
module fetch_pipe
    import cpu_pkg::*;
#(
    parameter int           D     = D_DEFAULT,
    parameter int           IW    = IW_DEFAULT,
    parameter logic [D-1:0] START = '0,
    parameter int           CW    = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          branch_en,
    input  logic [D-1:0]  branch_target,
    output logic [D-1:0]  imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic          id_valid,
    output logic [IW-1:0] id_instr,
    output logic [D-1:0]  id_pc,
    output logic          done,
    output logic [CW-1:0] cycle_count,
    output logic [CW-1:0] retire_count
);

    localparam logic [IW-1:0] HALT_INSTR = {IW{HALT_CODE[0]}};
    localparam logic [IW-1:0] NOP_INSTR  = {IW{NOP_CODE[0]}};
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX    = '1;

    fetch_state_t state, state_nxt;
    logic [D-1:0] pc;
    logic         running;
    logic         advance;     // IF/ID may change this edge
    logic         halt_take;   // halt instruction leaves ID this edge
    logic         pc_hold;

    assign running   = (state == RUN);
    assign advance   = running && !stall;
    assign halt_take = advance && id_valid && (id_instr == HALT_INSTR);
    // The halt edge freezes the PC so imem_addr stays on the next unexecuted word.
    assign pc_hold   = !advance || halt_take;

    fetch_pc #(
        .D     (D),
        .START (START)
    ) u_pc (
        .clk      (clk),
        .rst_n    (reset),
        .hold     (pc_hold),
        .load     (branch_en),
        .load_val (branch_target),
        .pc       (pc)
    );

    assign imem_addr = pc;
    assign done      = (state == HALT);

    // FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (halt_take) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    // IF/ID register. id_pc is left alone on bubbles; it is only
    // meaningful while id_valid is set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= '0;
        end else if (advance) begin
            if (halt_take || branch_en) begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end else begin
                id_valid <= 1'b1;
                id_instr <= imem_data;
                id_pc    <= pc;
            end
        end
    end

    // Saturating performance counters, frozen once halted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count  <= '0;
            retire_count <= '0;
        end else if (running) begin
            if (cycle_count != CNT_MAX) begin
                cycle_count <= cycle_count + CNT_ONE;
            end
            if (id_valid && !stall && (retire_count != CNT_MAX)) begin
                retire_count <= retire_count + CNT_ONE;
            end
        end
    end

endmodule
